grant_decoder: RTL and testbench

- Sequential counterpart to the team's 4-input priority encoder: takes 2-bit encoded request codes and turns each into a one-hot 4-bit grant.
- Accepted codes are buffered in a small FIFO. Each grant is presented and held until the consumer acknowledges it.
- Sits between the request encoder and the four requesters; the decoded grant line drives the selected requester.
- Code mapping (binary): 00→grant[0], 01→grant[1], 10→grant[2], 11→grant[3].

---
 rtl/grant_decoder.sv | 118 +++++++++++
 tb/tb_grant_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/grant_decoder.sv
// Sequential grant decoder: buffers 2-bit request codes in a FIFO and presents
// each as a registered one-hot grant, held until the consumer acknowledges it.
module grant_decoder #(
  parameter int DEPTH = 4,
  parameter int CW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CW-1:0]           in_code,
  output logic [(2**CW)-1:0]      grant,
  output logic                    grant_valid,
  input  logic                    grant_ack,
  output logic [CW-1:0]           last_code,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int GW   = 2**CW;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     mem_q [DEPTH];
  logic [CW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic [CW-1:0]     last_code_q, last_code_d;
  logic [CW-1:0]     head;
  logic              push;
  logic              pop;

  // Occupancy-only backpressure; a pop at the same edge never frees a slot early.
  assign in_ready = (count_q < CNTW'(DEPTH)) && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    last_code_d   = last_code_q;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      GRANT: begin
        if (grant_ack) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            grant_d       = '0;
            grant_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The popped entry is always the old head, so a concurrent write cannot bypass.
    if (pop) begin
      grant_d       = GW'(1) << head;
      last_code_d   = head;
      grant_valid_d = 1'b1;
      state_d       = GRANT;
      rd_ptr_d      = rd_ptr_q + 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = in_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      last_code_q   <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      last_code_q   <= last_code_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign last_code   = last_code_q;
  assign count       = count_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Directed bench for grant_decoder with a scoreboard queue of accepted codes.
module tb_grant_decoder;

  localparam int DEPTH = 4;
  localparam int CW    = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_code;
  logic [3:0]  grant;
  logic        grant_valid;
  logic        grant_ack;
  logic [1:0]  last_code;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [1:0] sb[$];
  logic       m_valid;
  logic [1:0] m_code;
  logic [1:0] m_last;

  grant_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .grant(grant), .grant_valid(grant_valid),
    .grant_ack(grant_ack), .last_code(last_code), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_valid = 1'b0;
    m_code  = 2'b00;
    m_last  = 2'b00;
  endtask

  task automatic chk_outputs(input string tag);
    logic [3:0] eg;
    eg = m_valid ? (4'b0001 << m_code) : 4'b0000;
    chk({tag, ".grant"},       {4'b0, grant},       {4'b0, eg});
    chk({tag, ".grant_valid"}, {7'b0, grant_valid}, {7'b0, m_valid});
    chk({tag, ".last_code"},   {6'b0, last_code},   {6'b0, m_last});
    chk({tag, ".count"},       {5'b0, count},       8'(sb.size()));
  endtask

  // Called at edge+1 with inputs already driven: checks in_ready, advances one edge, checks outputs.
  task automatic tick(input string tag);
    logic acc;
    logic pop;
    acc = in_valid && (sb.size() < DEPTH);
    chk({tag, ".in_ready"}, {7'b0, in_ready}, {7'b0, sb.size() < DEPTH});
    pop = (sb.size() > 0) && (!m_valid || grant_ack);
    if (pop) begin
      m_code  = sb.pop_front();
      m_last  = m_code;
      m_valid = 1'b1;
    end else if (m_valid && grant_ack) begin
      m_valid = 1'b0;
    end
    if (acc) sb.push_back(in_code);
    @(posedge clk);
    #1;
    chk_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic a);
    in_valid  = v;
    in_code   = c;
    grant_ack = a;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 2'b11, 1'b0);
    model_reset();

    // Reset held with in_valid asserted
    #2;
    chk("rst.in_ready", {7'b0, in_ready}, 8'h00);
    chk_outputs("rst");
    #10;
    chk("rst_edge.in_ready", {7'b0, in_ready}, 8'h00);
    chk_outputs("rst_edge");
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rel.in_ready", {7'b0, in_ready}, 8'h01);

    // Single code 01, ack two cycles after the grant appears
    drive(1'b1, 2'b01, 1'b0); tick("single_push");
    drive(1'b0, 2'b00, 1'b0); tick("single_grant");
    chk("single.grant_abs", {4'b0, grant}, 8'h02);
    tick("single_hold");
    drive(1'b0, 2'b00, 1'b1); tick("single_ack");
    chk("single.last_abs", {6'b0, last_code}, 8'h01);
    tick("idle_ack_ignored");
    drive(1'b0, 2'b00, 1'b0);

    // Fill without ack: five accepted, sixth blocked
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'(i), 1'b0);
      tick($sformatf("fill%0d", i));
    end
    tick("fill_blocked");
    chk("fill.count_abs", {5'b0, count}, 8'h04);
    chk("fill.grant_abs", {4'b0, grant}, 8'h01);
    chk("fill.in_ready_abs", {7'b0, in_ready}, 8'h00);

    // Drain with ack held
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      tick($sformatf("drain%0d", i));
    end
    chk("drain.grant_valid_abs", {7'b0, grant_valid}, 8'h00);
    drive(1'b0, 2'b00, 1'b0);
    tick("drain_idle");

    // Simultaneous push and pop with count=2
    drive(1'b1, 2'b10, 1'b0); tick("sim_a");
    drive(1'b1, 2'b00, 1'b0); tick("sim_b");
    drive(1'b1, 2'b01, 1'b0); tick("sim_c");
    chk("sim.count_pre", {5'b0, count}, 8'h02);
    drive(1'b1, 2'b11, 1'b1); tick("sim_pushpop");
    chk("sim.count_same", {5'b0, count}, 8'h02);
    chk("sim.old_head", {4'b0, grant}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b00, 1'b1);
      tick($sformatf("sim_drain%0d", i));
    end
    drive(1'b0, 2'b00, 1'b0);

    // Asynchronous reset mid-operation
    drive(1'b1, 2'b10, 1'b0); tick("mid_a");
    drive(1'b1, 2'b01, 1'b0); tick("mid_b");
    drive(1'b1, 2'b10, 1'b0); tick("mid_c");
    drive(1'b1, 2'b11, 1'b0); tick("mid_d");
    chk("mid.count_pre", {5'b0, count}, 8'h03);
    chk("mid.grant_pre", {4'b0, grant}, 8'h04);
    drive(1'b0, 2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst.in_ready", {7'b0, in_ready}, 8'h00);
    chk_outputs("mid_rst");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 2'b10, 1'b0); tick("post_push");
    drive(1'b0, 2'b00, 1'b0); tick("post_grant");
    chk("post.grant_abs", {4'b0, grant}, 8'h04);
    tick("post_no_stale");
    drive(1'b0, 2'b00, 1'b1); tick("post_ack");
    tick("post_idle");

    // Random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      tick($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
